// File: rtl/ex_alu_control_if.sv
// ID/EX-side bundle for the execute-stage ALU control: ID request, interlock and EX/md status.
// master drives the ID side; slave is the control block.
interface ex_alu_control_if;
  logic       id_valid;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       flush;
  logic       stall;
  logic       ex_valid;
  logic [3:0] alu_operation;
  logic       illegal;
  logic       md_start;
  logic       md_is_div;
  logic       md_busy;
  logic       md_done;

  modport master (
    output id_valid, alu_op, funct, flush,
    input  stall, ex_valid, alu_operation, illegal,
    input  md_start, md_is_div, md_busy, md_done
  );

  modport slave (
    input  id_valid, alu_op, funct, flush,
    output stall, ex_valid, alu_operation, illegal,
    output md_start, md_is_div, md_busy, md_done
  );
endinterface

// File: rtl/ex_alu_control.sv
// Execute-stage ALU control: decodes alu_op/funct into a registered ALU code and
// sequences multi-cycle MULT/DIV while interlocking HI/LO readers in ID.
module ex_alu_control #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = $clog2((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_alu_control_if.slave  ctl
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} md_state_t;

  md_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ex_valid_reg, ex_valid_next;
  logic [3:0]       op_reg, op_next;
  logic             illegal_reg, illegal_next;
  logic             start_reg, start_next;
  logic             is_div_reg, is_div_next;

  logic [3:0] op_dec;
  logic       illegal_dec;
  logic       dec_mult;
  logic       dec_div;
  logic       dec_hilo;
  logic       md_busy;
  logic       md_done;
  logic       stall;
  logic       capture;
  logic       issue;

  always_comb begin
    op_dec      = OP_ADD;
    illegal_dec = 1'b0;
    dec_mult    = 1'b0;
    dec_div     = 1'b0;
    dec_hilo    = 1'b0;
    unique case (ctl.alu_op)
      2'b00: op_dec = OP_ADD;
      2'b01: op_dec = OP_SUB;
      2'b10: begin
        unique case (ctl.funct)
          6'b100000: op_dec = OP_ADD;
          6'b100010: op_dec = OP_SUB;
          6'b100100: op_dec = OP_AND;
          6'b100101: op_dec = OP_OR;
          6'b100111: op_dec = OP_NOR;
          6'b101010: op_dec = OP_SLT;
          6'b011000: begin op_dec = OP_ADD;  dec_mult = 1'b1; end
          6'b011010: begin op_dec = OP_ADD;  dec_div  = 1'b1; end
          6'b010000: begin op_dec = OP_MFHI; dec_hilo = 1'b1; end
          6'b010010: begin op_dec = OP_MFLO; dec_hilo = 1'b1; end
          default:   begin op_dec = OP_SUB;  illegal_dec = 1'b1; end
        endcase
      end
      default: begin op_dec = OP_ADD; illegal_dec = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      ex_valid_reg <= 1'b0;
      op_reg       <= 4'b0000;
      illegal_reg  <= 1'b0;
      start_reg    <= 1'b0;
      is_div_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ex_valid_reg <= ex_valid_next;
      op_reg       <= op_next;
      illegal_reg  <= illegal_next;
      start_reg    <= start_next;
      is_div_reg   <= is_div_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    md_busy    = (state_reg != S_IDLE);
    md_done    = md_busy && (cnt_reg == '0);
    // md_done releases the interlock so a held op issues back-to-back with the finishing one
    stall      = ctl.id_valid && (dec_mult || dec_div || dec_hilo) && md_busy && !md_done && !ctl.flush;
    capture    = ctl.id_valid && !stall && !ctl.flush;
    issue      = capture && (dec_mult || dec_div);

    ex_valid_next = capture;
    op_next       = capture ? op_dec : 4'b0000;
    illegal_next  = capture && illegal_dec;
    start_next    = issue;
    is_div_next   = issue ? dec_div : is_div_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (issue) begin
          state_next = dec_div ? S_DIV : S_MUL;
          cnt_next   = dec_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      default: begin
        if (md_done) begin
          if (issue) begin
            state_next = dec_div ? S_DIV : S_MUL;
            cnt_next   = dec_div ? DIV_LOAD : MUL_LOAD;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
    endcase
  end

  assign ctl.stall         = stall;
  assign ctl.ex_valid      = ex_valid_reg;
  assign ctl.alu_operation = op_reg;
  assign ctl.illegal       = illegal_reg;
  assign ctl.md_start      = start_reg;
  assign ctl.md_is_div     = is_div_reg;
  assign ctl.md_busy       = md_busy;
  assign ctl.md_done       = md_done;

endmodule

// File: tb/tb_ex_alu_control.sv
// Bench for ex_alu_control: directed test-plan sequences then random traffic, every cycle
// compared against a remaining-cycles reference model.
module tb_ex_alu_control;
  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;

  logic clk;
  logic rst_n;
  ex_alu_control_if ifc ();

  ex_alu_control #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (ifc.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // reference state: remaining busy cycles (0 = idle) plus the expected registered outputs
  int         m_left;
  bit         m_ev, m_ill, m_start, m_div;
  logic [3:0] m_op;
  bit         last_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // kind: 0 plain, 1 MULT, 2 DIV, 3 HI/LO read
  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                     output logic [3:0] code, output bit ill, output int kind);
    code = 4'b0010; ill = 0; kind = 0;
    if (op == 2'b00) code = 4'b0010;
    else if (op == 2'b01) code = 4'b0110;
    else if (op == 2'b11) ill = 1;
    else begin
      case (f)
        F_ADD:   code = 4'b0010;
        F_SUB:   code = 4'b0110;
        F_AND:   code = 4'b0000;
        F_OR:    code = 4'b0001;
        F_NOR:   code = 4'b1100;
        F_SLT:   code = 4'b0111;
        F_MULT:  kind = 1;
        F_DIV:   kind = 2;
        F_MFHI:  begin code = 4'b1010; kind = 3; end
        F_MFLO:  begin code = 4'b1011; kind = 3; end
        default: begin code = 4'b0110; ill = 1; end
      endcase
    end
  endfunction

  task automatic model_reset();
    m_left = 0; m_ev = 0; m_ill = 0; m_start = 0; m_div = 0; m_op = 4'b0000;
  endtask

  // inputs are already applied at posedge+1; check at the falling edge, then advance the model
  task automatic cycle();
    logic [3:0] code;
    bit ill, busy, done, exp_stall, cap, issue, rn;
    int kind;
    #4;
    ref_decode(ifc.alu_op, ifc.funct, code, ill, kind);
    busy      = (m_left > 0);
    done      = (m_left == 1);
    exp_stall = ifc.id_valid && (kind != 0) && busy && !done && !ifc.flush;
    cap       = ifc.id_valid && !exp_stall && !ifc.flush;
    issue     = cap && (kind == 1 || kind == 2);
    check_eq("stall",     ifc.stall,         exp_stall);
    check_eq("ex_valid",  ifc.ex_valid,      m_ev);
    check_eq("alu_op",    ifc.alu_operation, m_op);
    check_eq("illegal",   ifc.illegal,       m_ill);
    check_eq("md_start",  ifc.md_start,      m_start);
    check_eq("md_is_div", ifc.md_is_div,     m_div);
    check_eq("md_busy",   ifc.md_busy,       busy);
    check_eq("md_done",   ifc.md_done,       done);
    if (ifc.id_valid)
      $display("txn t=%0t alu_op=%b funct=%h flush=%b rst_n=%b stall=%b captured=%b",
               $time, ifc.alu_op, ifc.funct, ifc.flush, rst_n, exp_stall, cap && rst_n);
    last_stall = exp_stall;
    rn = rst_n;
    @(posedge clk);
    #1;
    if (!rn) model_reset();
    else begin
      m_ev    = cap;
      m_op    = cap ? code : 4'b0000;
      m_ill   = cap && ill;
      m_start = issue;
      if (issue) begin
        m_div  = (kind == 2);
        m_left = (kind == 2) ? DIV_N : MUL_N;
      end else if (busy) begin
        m_left = m_left - 1;
      end
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [5:0] f,
                       input bit fl, input bit rn);
    ifc.id_valid = v;
    ifc.alu_op   = op;
    ifc.funct    = f;
    ifc.flush    = fl;
    rst_n        = rn;
    cycle();
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) drive(0, 2'b00, 6'h00, 0, 1);
  endtask

  // present an R-type until it leaves ID
  task automatic hold_rtype(input logic [5:0] f);
    int n = 0;
    do begin
      drive(1, 2'b10, f, 0, 1);
      n++;
    end while (last_stall && n < 100);
    if (last_stall) begin
      n_checks++;
      n_errors++;
      $display("FAIL hold_timeout funct=%h still stalled after %0d cycles, required release", f, n);
    end
  endtask

  initial begin
    logic [5:0] fset [12];
    fset = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_MULT, F_DIV, F_MFHI, F_MFLO, 6'h3F, 6'h00};
    ifc.id_valid = 0; ifc.alu_op = 0; ifc.funct = 0; ifc.flush = 0;
    rst_n = 0;
    @(posedge clk);
    #1;
    model_reset();
    nop(2);

    // plain decode, back-to-back
    drive(1, 2'b10, F_ADD, 0, 1);
    drive(1, 2'b10, F_SUB, 0, 1);
    drive(1, 2'b10, F_AND, 0, 1);
    drive(1, 2'b10, F_OR,  0, 1);
    drive(1, 2'b10, F_NOR, 0, 1);
    drive(1, 2'b10, F_SLT, 0, 1);
    drive(1, 2'b00, 6'h00, 0, 1);
    drive(1, 2'b01, 6'h00, 0, 1);
    drive(1, 2'b10, 6'h3F, 0, 1);
    drive(1, 2'b11, 6'h00, 0, 1);
    nop(1);

    // MULT then held MFLO; then MULT, ADD passes, MFLO held
    drive(1, 2'b10, F_MULT, 0, 1);
    hold_rtype(F_MFLO);
    nop(2);
    drive(1, 2'b10, F_MULT, 0, 1);
    drive(1, 2'b10, F_ADD, 0, 1);
    hold_rtype(F_MFLO);
    nop(2);

    // DIV followed by MULT back-to-back
    drive(1, 2'b10, F_DIV, 0, 1);
    hold_rtype(F_MULT);
    nop(MUL_N + 1);

    // flush cases
    drive(1, 2'b10, F_MULT, 1, 1);
    nop(1);
    drive(1, 2'b10, F_MULT, 0, 1);
    drive(1, 2'b10, F_MFHI, 0, 1);
    drive(1, 2'b10, F_MFHI, 1, 1);
    nop(MUL_N);

    // reset in the 2nd busy cycle of DIV, then a normal MULT
    drive(1, 2'b10, F_DIV, 0, 1);
    nop(1);
    drive(0, 2'b00, 6'h00, 0, 0);
    nop(2);
    drive(1, 2'b10, F_MULT, 0, 1);
    nop(MUL_N + 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bit v, fl, rn;
      logic [1:0] op;
      logic [5:0] f;
      v  = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 9) == 0);
      rn = ($urandom_range(0, 99) != 0);
      op = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
      f  = ($urandom_range(0, 7) != 0) ? fset[$urandom_range(0, 11)] : 6'($urandom);
      drive(v, op, f, fl, rn);
    end
    nop(DIV_N + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
